nim_turn_controller: RTL and testbench

- Sequences a two-player game of Nim on the four stick rows shown on the 8x8 LED display.
- Consumes single-cycle button pulses from the debouncers and owns the heap counts and turn state.
- Enforces the Nim move rules (at least one stick, from one row only, per turn) and detects the winner.
- Its count and player outputs drive the image builder that feeds display_8x8.

---
 rtl/nim_pkg.sv | 25 ++
 rtl/nim_turn_controller_if.sv | 27 ++
 rtl/nim_heap_counter.sv | 23 ++
 rtl/nim_turn_controller.sv | 142 ++++++++++++++
 tb/tb_nim_turn_controller.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nim_pkg.sv
// Shared types and constants for the Nim turn controller.
package nim_pkg;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    TAKING = 2'd1,
    OVER   = 2'd2
  } state_t;

  localparam int NUM_ROWS  = 4;

  // Default starting sticks per row (classic 1/3/5/7 layout)
  localparam int H1_INIT_D = 1;
  localparam int H2_INIT_D = 3;
  localparam int H3_INIT_D = 5;
  localparam int H4_INIT_D = 7;

  // locked_row encodings
  localparam logic [2:0] ROW_NONE = 3'd0;
  localparam logic [2:0] ROW1     = 3'd1;
  localparam logic [2:0] ROW2     = 3'd2;
  localparam logic [2:0] ROW3     = 3'd3;
  localparam logic [2:0] ROW4     = 3'd4;

endpackage

// File: rtl/nim_turn_controller_if.sv
// Button pulses in, game state out, between debouncers/image builder and the controller.
interface nim_turn_controller_if #(parameter int CW = 3);
  logic [3:0]    take_pulse;
  logic          end_turn_pulse;
  logic          new_game_pulse;
  logic [CW-1:0] heap1_cnt;
  logic [CW-1:0] heap2_cnt;
  logic [CW-1:0] heap3_cnt;
  logic [CW-1:0] heap4_cnt;
  logic          cur_player;
  logic [2:0]    locked_row;
  logic          game_over;
  logic          winner;
  logic          move_err;

  modport master (
    output take_pulse, end_turn_pulse, new_game_pulse,
    input  heap1_cnt, heap2_cnt, heap3_cnt, heap4_cnt,
    input  cur_player, locked_row, game_over, winner, move_err
  );

  modport slave (
    input  take_pulse, end_turn_pulse, new_game_pulse,
    output heap1_cnt, heap2_cnt, heap3_cnt, heap4_cnt,
    output cur_player, locked_row, game_over, winner, move_err
  );
endinterface

// File: rtl/nim_heap_counter.sv
// One stick row: loadable down-counter that never wraps below zero.
module nim_heap_counter #(
  parameter int CW   = 3,
  parameter int INIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec_en,
  output logic [CW-1:0] cnt,
  output logic          empty
);

  assign empty = (cnt == '0);

  // Reload on reset/new game, otherwise count down while sticks remain
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= INIT[CW-1:0];
    else if (load)             cnt <= INIT[CW-1:0];
    else if (dec_en && !empty) cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/nim_turn_controller.sv
// Nim game sequencer: applies take/end-turn/new-game pulses, enforces move rules, finds the winner.
module nim_turn_controller
  import nim_pkg::*;
#(
  parameter int H1_INIT = H1_INIT_D,
  parameter int H2_INIT = H2_INIT_D,
  parameter int H3_INIT = H3_INIT_D,
  parameter int H4_INIT = H4_INIT_D,
  parameter int CW      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  nim_turn_controller_if.slave bus
);

  localparam int HINIT [NUM_ROWS] = '{H1_INIT, H2_INIT, H3_INIT, H4_INIT};

  state_t state, nxt_state;

  logic [NUM_ROWS-1:0][CW-1:0] heap_cnt;
  logic [NUM_ROWS-1:0]         empty, dec_en;
  logic                        load;

  logic       player_q, winner_q, over_q, err_q;
  logic [2:0] locked_q;
  logic       nxt_player, nxt_winner, nxt_over, nxt_err;
  logic [2:0] nxt_locked;

  logic       take_any, take_ok, last_stick;
  logic [1:0] k;
  logic [2:0] k_row;

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_heap
    nim_heap_counter #(.CW(CW), .INIT(HINIT[g])) u_heap (
      .clk   (clk),
      .rst   (reset),
      .load  (load),
      .dec_en(dec_en[g]),
      .cnt   (heap_cnt[g]),
      .empty (empty[g])
    );
  end

  // Decode the take request: which row, and whether it is a legal move
  always_comb begin
    k = 2'd0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (bus.take_pulse[i]) k = i[1:0];
    k_row    = {1'b0, k} + 3'd1;
    take_any = |bus.take_pulse;
    take_ok  = (state != OVER) && $onehot(bus.take_pulse) && !empty[k] &&
               ((locked_q == ROW_NONE) || (locked_q == k_row));
    // Last stick: this row holds one and every other row is already empty
    last_stick = take_ok && (heap_cnt[k] == {{(CW-1){1'b0}}, 1'b1}) &&
                 (&(empty | bus.take_pulse));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SELECT;
    else       state <= nxt_state;
  end

  // Next-state logic: new game beats take beats end turn; OVER only left via new game
  always_comb begin
    nxt_state = state;
    if (bus.new_game_pulse)
      nxt_state = SELECT;
    else if (state != OVER) begin
      if (take_any) begin
        if (take_ok) nxt_state = last_stick ? OVER : TAKING;
      end else if (bus.end_turn_pulse && state == TAKING)
        nxt_state = SELECT;
    end
  end

  // Output/next-register logic; an end_turn riding on a take is dropped and flagged
  always_comb begin
    nxt_player = player_q;
    nxt_winner = winner_q;
    nxt_over   = over_q;
    nxt_locked = locked_q;
    nxt_err    = 1'b0;
    dec_en     = '0;
    load       = 1'b0;
    if (bus.new_game_pulse) begin
      load       = 1'b1;
      nxt_player = (state == OVER) ? ~winner_q : player_q;
      nxt_winner = 1'b0;
      nxt_over   = 1'b0;
      nxt_locked = ROW_NONE;
    end else if (state != OVER) begin
      if (take_any) begin
        if (take_ok) begin
          dec_en[k] = 1'b1;
          nxt_err   = bus.end_turn_pulse;
          if (last_stick) begin
            nxt_over   = 1'b1;
            nxt_winner = player_q;
            nxt_locked = ROW_NONE;
          end else
            nxt_locked = k_row;
        end else
          nxt_err = 1'b1;
      end else if (bus.end_turn_pulse) begin
        if (state == TAKING) begin
          nxt_player = ~player_q;
          nxt_locked = ROW_NONE;
        end else
          nxt_err = 1'b1;
      end
    end
  end

  // Registered game outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_q <= 1'b0;
      winner_q <= 1'b0;
      over_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= ROW_NONE;
    end else begin
      player_q <= nxt_player;
      winner_q <= nxt_winner;
      over_q   <= nxt_over;
      err_q    <= nxt_err;
      locked_q <= nxt_locked;
    end
  end

  assign bus.heap1_cnt  = heap_cnt[0];
  assign bus.heap2_cnt  = heap_cnt[1];
  assign bus.heap3_cnt  = heap_cnt[2];
  assign bus.heap4_cnt  = heap_cnt[3];
  assign bus.cur_player = player_q;
  assign bus.locked_row = locked_q;
  assign bus.game_over  = over_q;
  assign bus.winner     = winner_q;
  assign bus.move_err   = err_q;

endmodule

// File: tb/tb_nim_turn_controller.sv
// Scoreboard bench for nim_turn_controller: reference model pushes expected outputs per cycle.
module tb_nim_turn_controller;
  localparam int CW = 3;
  typedef logic [18:0] snap_t; // {h4,h3,h2,h1,player,locked,over,winner,err}

  localparam snap_t RST_SNAP = {3'd7, 3'd5, 3'd3, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nim_turn_controller_if #(.CW(CW)) bus();

  nim_turn_controller #(
    .H1_INIT(1), .H2_INIT(3), .H3_INIT(5), .H4_INIT(7), .CW(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  snap_t sb[$];
  snap_t exp_v;
  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  int   m_heap [4];
  int   m_locked;
  logic m_player, m_over, m_winner;

  function automatic snap_t snap();
    return {bus.heap4_cnt, bus.heap3_cnt, bus.heap2_cnt, bus.heap1_cnt,
            bus.cur_player, bus.locked_row, bus.game_over, bus.winner, bus.move_err};
  endfunction

  function automatic snap_t model_snap(input logic err);
    return {m_heap[3][2:0], m_heap[2][2:0], m_heap[1][2:0], m_heap[0][2:0],
            m_player, m_locked[2:0], m_over, m_winner, err};
  endfunction

  task automatic model_reset(input logic keep_player);
    m_heap[0] = 1; m_heap[1] = 3; m_heap[2] = 5; m_heap[3] = 7;
    m_locked = 0; m_over = 1'b0; m_winner = 1'b0;
    if (!keep_player) m_player = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] t, input logic e, input logic n);
    logic err;
    int   row;
    err = 1'b0;
    row = 0;
    if (n) begin
      if (m_over) m_player = ~m_winner;
      model_reset(1'b1);
    end else if (m_over) begin
      err = 1'b0;
    end else if (t != 4'd0) begin
      if ($countones(t) != 1) err = 1'b1;
      else begin
        for (int i = 0; i < 4; i++) if (t[i]) row = i;
        if (m_heap[row] == 0 || (m_locked != 0 && m_locked != row + 1)) err = 1'b1;
        else begin
          m_heap[row]--;
          m_locked = row + 1;
          if (m_heap[0] + m_heap[1] + m_heap[2] + m_heap[3] == 0) begin
            m_over = 1'b1; m_winner = m_player; m_locked = 0;
          end
          if (e) err = 1'b1;
        end
      end
    end else if (e) begin
      if (m_locked == 0) err = 1'b1;
      else begin
        m_player = ~m_player;
        m_locked = 0;
      end
    end
    sb.push_back(model_snap(err));
  endtask

  // Drive one cycle of pulses (called at posedge+1), sample at next posedge+1
  task automatic cyc(input logic [3:0] t, input logic e, input logic n);
    bus.take_pulse     = t;
    bus.end_turn_pulse = e;
    bus.new_game_pulse = n;
    model_step(t, e, n);
    @(posedge clk);
    #1;
    bus.take_pulse     = 4'd0;
    bus.end_turn_pulse = 1'b0;
    bus.new_game_pulse = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.take_pulse = 4'd0; bus.end_turn_pulse = 1'b0; bus.new_game_pulse = 1'b0;
    model_reset(1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc(4'd0, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    n_cmp++;
    if (snap() !== RST_SNAP) begin
      n_err++; $display("FAIL reset_state: got %h want %h", snap(), RST_SNAP);
    end
    n_cmp++;
    if (snap() !== exp_v) begin
      n_err++; $display("FAIL reset_model: got %h want %h", snap(), exp_v);
    end
  endtask

  task automatic test_take_row4();
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1000, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (snap() !== exp_v) begin
        n_err++; $display("FAIL take_r4_%0d: got %h want %h", i, snap(), exp_v);
      end
    end
    n_cmp++;
    if (bus.heap4_cnt !== 3'd4 || bus.locked_row !== 3'd4) begin
      n_err++; $display("FAIL take_r4_locked: got h4=%0d lock=%0d want 4/4", bus.heap4_cnt, bus.locked_row);
    end
    cyc(4'd0, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    n_cmp++;
    if (snap() !== exp_v || bus.cur_player !== 1'b1 || bus.locked_row !== 3'd0) begin
      n_err++; $display("FAIL end_turn: got %h want %h", snap(), exp_v);
    end
  endtask

  task automatic test_lock_violation();
    logic [3:0] t [3] = '{4'b0010, 4'b0100, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      cyc(t[i], 1'b0, 1'b0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (snap() !== exp_v) begin
        n_err++; $display("FAIL lock_viol_%0d: got %h want %h", i, snap(), exp_v);
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.move_err !== 1'b1 || bus.heap2_cnt !== 3'd2 || bus.heap3_cnt !== 3'd5) begin
          n_err++; $display("FAIL lock_viol_err: got err=%b h2=%0d h3=%0d want 1/2/5",
                            bus.move_err, bus.heap2_cnt, bus.heap3_cnt);
        end
      end
    end
    n_cmp++;
    if (bus.move_err !== 1'b0) begin
      n_err++; $display("FAIL err_one_cycle: got %b want 0", bus.move_err);
    end
  endtask

  task automatic test_errors();
    // B ends, A ends in SELECT (err), A empties row1, B ends... B takes row1 (err), B takes 0011 (err)
    logic [3:0] t [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0011};
    logic       e [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       want_err [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cyc(t[i], e[i], 1'b0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (snap() !== exp_v || bus.move_err !== want_err[i]) begin
        n_err++; $display("FAIL errors_%0d: got %h want %h", i, snap(), exp_v);
      end
    end
  endtask

  task automatic test_play_out();
    // B: row2 x2 end; A: row3 x5 end; B: row4 x3 end; A: row4 (last stick)
    logic [3:0] t [16] = '{4'b0010, 4'b0010, 4'b0000,
                           4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                           4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000,
                           4'b1000, 4'b0011};
    logic       e [16] = '{1'b0, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                           1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      cyc(t[i], e[i], 1'b0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (snap() !== exp_v) begin
        n_err++; $display("FAIL play_%0d: got %h want %h", i, snap(), exp_v);
      end
      if (i >= 13) begin
        n_cmp++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b0 || bus.move_err !== 1'b0 ||
            {bus.heap4_cnt, bus.heap3_cnt, bus.heap2_cnt, bus.heap1_cnt} !== 12'd0) begin
          n_err++; $display("FAIL over_%0d: got over=%b win=%b err=%b want 1/0/0",
                            i, bus.game_over, bus.winner, bus.move_err);
        end
      end
    end
    cyc(4'd0, 1'b0, 1'b1);
    exp_v = sb.pop_front();
    n_cmp++;
    if (snap() !== {3'd7, 3'd5, 3'd3, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL new_game: got %h want player1 fresh heaps", snap());
    end
    n_cmp++;
    if (snap() !== exp_v) begin
      n_err++; $display("FAIL new_game_model: got %h want %h", snap(), exp_v);
    end
  endtask

  task automatic test_take_with_end();
    cyc(4'b0100, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    n_cmp++;
    if (snap() !== exp_v || bus.move_err !== 1'b1 || bus.locked_row !== 3'd3) begin
      n_err++; $display("FAIL take_with_end: got %h want %h", snap(), exp_v);
    end
    cyc(4'd0, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    n_cmp++;
    if (snap() !== exp_v) begin
      n_err++; $display("FAIL take_with_end_pass: got %h want %h", snap(), exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] t;
    logic       e, n;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(9))
        0, 1, 2, 3, 4, 5: t = 4'(4'b0001 << $urandom_range(3));
        6:                t = 4'($urandom_range(15));
        default:          t = 4'd0;
      endcase
      e = ($urandom_range(3) == 0);
      n = ($urandom_range(39) == 0);
      cyc(t, e, n);
      exp_v = sb.pop_front();
      n_cmp++;
      if (snap() !== exp_v) begin
        n_err++; $display("FAIL b2b_%0d: got %h want %h (t=%b e=%b n=%b)", i, snap(), exp_v, t, e, n);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(4'd0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      n_cmp++;
      if (snap() !== exp_v) begin
        n_err++; $display("FAIL pre_reset_%0d: got %h want %h", i, snap(), exp_v);
      end
    end
    n_cmp++;
    if (bus.heap3_cnt !== 3'd2 || bus.locked_row !== 3'd3) begin
      n_err++; $display("FAIL pre_reset_taking: got h3=%0d lock=%0d want 2/3", bus.heap3_cnt, bus.locked_row);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (snap() !== RST_SNAP) begin
      n_err++; $display("FAIL async_reset: got %h want %h", snap(), RST_SNAP);
    end
    model_reset(1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(4'b0100, 1'b0, 1'b0);
    exp_v = sb.pop_front();
    n_cmp++;
    if (snap() !== exp_v) begin
      n_err++; $display("FAIL post_reset_take: got %h want %h", snap(), exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_take_row4();
    test_lock_violation();
    test_errors();
    test_play_out();
    test_take_with_end();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
